// File: rtl/lfsr_seq_ctrl.sv
// Start/stream/done sequencer around a Fibonacci LFSR with a valid/ready output,
// period measurement and all-zero seed detection.
module lfsr_seq_ctrl #(
   parameter int unsigned    N     = 3,
   parameter logic [N-1:0]   TAPS  = 3'b110,
   parameter int unsigned    CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [N-1:0]     seed,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             lockup_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [CNT_W-1:0] period
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q;
   logic [N-1:0]     lfsr_q;
   logic [N-1:0]     seed_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] period_q;
   logic             busy_q;
   logic             done_q;
   logic             lockup_q;
   logic             valid_q;

   logic [N-1:0]     lfsr_d;
   logic [CNT_W-1:0] count_d;
   logic             handshake;

   assign lfsr_d    = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
   assign count_d   = count_q + CNT_W'(1);
   assign handshake = valid_q & out_ready;

   // NOTE: every register below uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         lfsr_q   <= '0;
         seed_q   <= '0;
         len_q    <= '0;
         count_q  <= '0;
         period_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lockup_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  lfsr_q   <= seed;
                  seed_q   <= seed;
                  len_q    <= len;
                  count_q  <= '0;
                  period_q <= '0;
                  lockup_q <= (seed == '0);
                  if (seed == '0 || len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     valid_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               // abort wins over a coincident handshake: that word is dropped uncounted
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end else if (handshake) begin
                  lfsr_q  <= lfsr_d;
                  count_q <= count_d;
                  if (period_q == '0 && lfsr_d == seed_q) begin
                     period_q <= count_d;
                  end
                  if (count_d == len_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign lockup_err = lockup_q;
   assign out_valid  = valid_q;
   assign out_data   = lfsr_q;
   assign period     = period_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: expected words queued at start, popped on handshakes.
module tb_lfsr_seq_ctrl;

   localparam int N     = 3;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [N-1:0]     seed;
   logic [CNT_W-1:0] len;
   logic             busy;
   logic             done;
   logic             lockup_err;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_data;
   logic [CNT_W-1:0] period;

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0] sb[$];
   logic [N-1:0] golden [10] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};

   always #5 clk = ~clk;

   lfsr_seq_ctrl #(.N(N), .TAPS(3'b110), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .seed       (seed),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .lockup_err (lockup_err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .period     (period)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_words(input int cnt);
      for (int i = 0; i < cnt; i++) sb.push_back(golden[i]);
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic start_run(input logic [N-1:0] seed_v, input logic [CNT_W-1:0] len_v);
      start = 1'b1;
      seed  = seed_v;
      len   = len_v;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input bit toggle, input int budget);
      int          last_hs = -10;
      bit          held_v  = 1'b0;
      bit          finished = 1'b0;
      logic [N-1:0] held   = '0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         if (done) begin
            check("done_latency", cyc, last_hs + 1);
            check("done_busy_valid_low", {30'd0, busy, out_valid}, 32'd0);
            finished = 1'b1;
         end else begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check("busy_eq_valid", busy, out_valid);
            if (out_valid) begin
               if (held_v) check("hold_stable", out_data, held);
               if (out_ready) begin
                  check("word_expected", sb.size() != 0, 1);
                  if (sb.size() != 0) check("data", out_data, sb.pop_front());
                  last_hs = cyc;
                  held_v  = 1'b0;
               end else begin
                  held   = out_data;
                  held_v = 1'b1;
               end
            end
            @(negedge clk);
         end
      end
      if (!finished) check("done_timeout", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      seed = '0; len = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_period", period, 0);
      check("rst_lockup", lockup_err, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: continuous ready, full period visible
      push_words(10);
      start_run(3'b001, 16'd10);
      check("t1_first_valid", out_valid, 1);
      check("t1_lockup", lockup_err, 0);
      drain(1'b0, 40);
      check("t1_period", period, 7);

      // 2: ready toggling, words held while stalled
      push_words(10);
      start_run(3'b001, 16'd10);
      check("t2_first_valid", out_valid, 1);
      drain(1'b1, 60);
      check("t2_period", period, 7);

      // 3: all-zero seed
      start_run(3'b000, 16'd5);
      check("t3_done", done, 1);
      check("t3_valid", out_valid, 0);
      check("t3_busy", busy, 0);
      check("t3_lockup", lockup_err, 1);
      @(negedge clk);
      check("t3_done_drop", done, 0);
      check("t3_no_valid", out_valid, 0);
      check("t3_period", period, 0);
      repeat (2) @(negedge clk);
      check("t3_lockup_held", lockup_err, 1);

      // 4: short run, seed never revisited
      push_words(3);
      start_run(3'b001, 16'd3);
      check("t4_lockup_clear", lockup_err, 0);
      drain(1'b0, 20);
      check("t4_period", period, 0);

      // 5: abort after 4 handshakes, concurrent handshake dropped, start in RUN ignored
      push_words(10);
      start_run(3'b001, 16'd10);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t5_data", out_data, sb.pop_front());
         start = (i == 2);
         seed  = 3'b100;
         len   = 16'd2;
         @(negedge clk);
      end
      start = 1'b0;
      check("t5_still_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      out_ready = 1'b0;
      check("t5_abort_valid", out_valid, 0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_done", done, 0);
      check("t5_word_not_counted", out_data, golden[4]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_done", done, 0);
         check("t5_start_not_queued", out_valid, 0);
      end
      check("t5_period_held", period, 0);
      sb.delete();

      // 6: asynchronous reset mid-run, then zero-length run
      push_words(10);
      start_run(3'b001, 16'd10);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t6_data", out_data, sb.pop_front());
         @(negedge clk);
      end
      check("t6_period_pre", period, 7);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_period", period, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_lockup", lockup_err, 0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b0;
      sb.delete();
      @(negedge clk);
      start_run(3'b101, 16'd0);
      check("t6_len0_done", done, 1);
      check("t6_len0_valid", out_valid, 0);
      check("t6_len0_lockup", lockup_err, 0);
      @(negedge clk);
      check("t6_len0_done_drop", done, 0);
      check("t6_len0_no_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
